up_bus_responder: RTL and testbench
===================================

Name: up_bus_responder

Overview:
- FPGA-side responder for the asynchronous 8-bit microprocessor handshake bus. Signals: start, handshake_1, RW, handshake_2, ack, bidirectional data.
- Per transaction it receives a command packet (command, register address, 32-bit data LSB first). It issues one register-bank access, then returns data and status (8 bytes, LSB first).
- Sits in motion_system between the uP pins and the internal register bank.

Parameters:
- RX_BYTES, 6, bytes received per transaction: cmd, addr, data[7:0] .. data[31:24].
- TX_BYTES, 8, bytes returned: data[7:0] .. data[31:24], then status[7:0] .. status[31:24].
- SYNC_STAGES, 2, flip-flops per asynchronous input synchroniser.
- TIMEOUT_CYCLES, 65535, handshake stall limit (used only with UP_BUS_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- async_uP_start  in  1  transaction start, asynchronous.
- async_uP_handshake_1  in  1  uP strobe, asynchronous.
- async_uP_RW  in  1  1 = uP drives uP_data; 0 = FPGA may drive; asynchronous.
- uP_handshake_2  out  1  FPGA strobe.
- uP_ack  out  1  transaction complete.
- uP_data  inout  8  shared data bus.
- bus_req  out  1  register access request.
- bus_cmd  out  8  latched command byte (0 = read, 1 = write).
- bus_addr  out  8  latched register address.
- bus_wdata  out  32  latched write data.
- bus_ack  in  1  register bank done; one-cycle pulse.
- bus_rdata  in  32  register data, valid with bus_ack.
- bus_status  in  32  status word, valid with bus_ack.
- timeout_err  out  1  sticky timeout flag; constant 0 without UP_BUS_TIMEOUT_EN.

Behaviour:
- Inputs: all three async inputs pass through SYNC_STAGES flip-flops before use. Start is edge-detected: a synchronised 0->1 transition triggers a transaction. A level is not sufficient, because the uP drops start after ~40 ns.
- Reset values: uP_handshake_2=0, uP_ack=0, bus_req=0, bus_cmd/bus_addr/bus_wdata=0, timeout_err=0, uP_data released (Z), state=IDLE, byte counter=0.
- Data bus: uP_data is driven only in TX_PRESENT/TX_WAIT_H1, and only while synced RW=0. Otherwise Z.
- IDLE: on start edge, clear uP_ack and byte counter, go to RX_WAIT_H1. A start edge in any other state is ignored.
- RX_WAIT_H1: when synced h1=1, capture uP_data into byte[counter] on that cycle and set handshake_2=1 the next cycle. Go to RX_WAIT_H1_LOW.
- RX_WAIT_H1_LOW: when synced h1=0, set handshake_2=0 and increment the counter. If counter reaches RX_BYTES go to EXEC, else go to RX_WAIT_H1.
- EXEC: assert bus_req with the latched cmd/addr/wdata. Hold until bus_ack. On bus_ack, drop bus_req, latch bus_rdata/bus_status into the 64-bit TX shift image, clear counter, go to TX_PRESENT.
- Command handling: the block does not interpret commands. Unknown commands still complete; the register bank reports them in status.
- TX_PRESENT: drive byte[counter] of the TX image. After one settling cycle set handshake_2=1 and go to TX_WAIT_H1.
- TX_WAIT_H1: when synced h1=1, set handshake_2=0 and go to TX_WAIT_H1_LOW.
- TX_WAIT_H1_LOW: when synced h1=0, increment the counter. If counter reaches TX_BYTES go to DONE, else go to TX_PRESENT.
- DONE: set uP_ack=1 and go to IDLE. uP_ack holds until the next start edge or reset.
- Counter: width clog2(max(RX_BYTES, TX_BYTES)+1); no wrap beyond limit.
- Reset mid-transaction: immediate return to reset values. A partial packet is discarded and no bus_req is issued.
- Latency: uP h1 edge to handshake_2 response is SYNC_STAGES+1 cycles.

Optional Feature:
- Macro UP_BUS_TIMEOUT_EN.
- Defined: a stall counter clears on every state change. If any state other than IDLE/EXEC persists for TIMEOUT_CYCLES cycles:
  - set timeout_err (sticky until reset);
  - force handshake_2=0, release the bus, drop bus_req;
  - go to IDLE without asserting uP_ack.
- Undefined: no counter logic; timeout_err tied 0; states wait indefinitely.

Test Plan:
- Write: start, write bytes 01,05,64,00,00,00; bank returns rdata=00000064, status=00000000 -> bus_req with cmd=01, addr=05, wdata=00000064. uP reads 64,00,00,00,00,00,00,00; uP_ack=1.
- Read: cmd 00, addr 05; bank rdata=DEADBEEF, status=00000001 -> read bytes EF,BE,AD,DE,01,00,00,00. uP_data is Z whenever RW=1.
- Handshake timing: measure h1 rise to handshake_2 rise -> 3-4 clk (SYNC_STAGES+1 plus async skew). handshake_2 never rises while h1 is still high from the previous byte.
- Reset after 3 received bytes: -> handshake_2=0, no bus_req, uP_data Z. The next full transaction completes correctly.
- bus_ack delayed 100 cycles -> bus_req held high 100 cycles; handshake_2 stays 0 until the TX phase.
- UP_BUS_TIMEOUT_EN defined, TIMEOUT_CYCLES=50, uP stops after byte 2 -> after 50 cycles timeout_err=1, state IDLE, uP_ack=0. The next start edge is accepted.

Source files
------------

// File: rtl/up_bus_responder.sv
// FPGA-side responder for the asynchronous 8-bit uP handshake bus: receives a 6-byte command packet,
// performs one register-bank access, and returns 8 bytes of data/status. Optional stall timeout: UP_BUS_TIMEOUT_EN.
module up_bus_responder #(
  parameter int unsigned RX_BYTES       = 6,
  parameter int unsigned TX_BYTES       = 8,
  parameter int unsigned SYNC_STAGES    = 2
`ifdef UP_BUS_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        async_uP_start,
  input  logic        async_uP_handshake_1,
  input  logic        async_uP_RW,
  output logic        uP_handshake_2,
  output logic        uP_ack,
  inout  wire  [7:0]  uP_data,
  output logic        bus_req,
  output logic [7:0]  bus_cmd,
  output logic [7:0]  bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic [31:0] bus_status,
  output logic        timeout_err
);

  localparam int unsigned MAX_BYTES = (RX_BYTES > TX_BYTES) ? RX_BYTES : TX_BYTES;
  localparam int unsigned CNT_W     = $clog2(MAX_BYTES + 1);

  typedef enum logic [2:0] {
    IDLE, RX_WAIT_H1, RX_WAIT_H1_LOW, EXEC,
    TX_PRESENT, TX_WAIT_H1, TX_WAIT_H1_LOW, DONE
  } state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [SYNC_STAGES-1:0] start_sync_q, h1_sync_q, rw_sync_q;
  logic                   start_prev_q;
  logic                   hs2_q, ack_q, req_q;
  logic [7:0]             cmd_q, addr_q;
  logic [31:0]            wdata_q;
  logic [63:0]            tx_img_q;
  logic                   start_s, h1_s, rw_s, start_edge, data_oe;

  assign start_s    = start_sync_q[SYNC_STAGES-1];
  assign h1_s       = h1_sync_q[SYNC_STAGES-1];
  assign rw_s       = rw_sync_q[SYNC_STAGES-1];
  assign start_edge = start_s & ~start_prev_q;

  // The uP pulses start for only ~2 clocks, so transactions trigger on the synchronised rising edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_sync_q <= '0;
      h1_sync_q    <= '0;
      rw_sync_q    <= '0;
      start_prev_q <= 1'b0;
    end else begin
      start_sync_q <= {start_sync_q[SYNC_STAGES-2:0], async_uP_start};
      h1_sync_q    <= {h1_sync_q[SYNC_STAGES-2:0], async_uP_handshake_1};
      rw_sync_q    <= {rw_sync_q[SYNC_STAGES-2:0], async_uP_RW};
      start_prev_q <= start_s;
    end
  end

  // Only present data while the uP has turned the bus around
  assign data_oe = ((state_q == TX_PRESENT) || (state_q == TX_WAIT_H1)) && !rw_s;
  assign uP_data = data_oe ? tx_img_q[7:0] : 8'hzz;

`ifdef UP_BUS_TIMEOUT_EN
  localparam int unsigned          STALL_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALL_W-1:0]   STALL_LIM = STALL_W'(TIMEOUT_CYCLES - 1);

  state_e               prev_state_q;
  logic [STALL_W-1:0]   stall_q;
  logic                 timeout_q;
  logic                 stall_hit;

  // stall_q holds (cycles spent in the current state - 1) once the state is stable
  assign stall_hit = (state_q == prev_state_q) && (stall_q == STALL_LIM) &&
                     (state_q != IDLE) && (state_q != EXEC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_state_q <= IDLE;
      stall_q      <= '0;
      timeout_q    <= 1'b0;
    end else begin
      prev_state_q <= state_q;
      if (state_q != prev_state_q) stall_q <= STALL_W'(1);
      else if (stall_q != STALL_LIM) stall_q <= stall_q + STALL_W'(1);
      if (stall_hit) timeout_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hs2_q    <= 1'b0;
      ack_q    <= 1'b0;
      req_q    <= 1'b0;
      cmd_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      tx_img_q <= '0;
    end else begin
`ifdef UP_BUS_TIMEOUT_EN
      if (stall_hit) begin
        hs2_q   <= 1'b0;
        req_q   <= 1'b0;
        state_q <= IDLE;
      end else
`endif
      begin
        unique case (state_q)
          IDLE: begin
            if (start_edge) begin
              ack_q   <= 1'b0;
              cnt_q   <= '0;
              state_q <= RX_WAIT_H1;
            end
          end
          RX_WAIT_H1: begin
            if (h1_s) begin
              if (cnt_q == '0) cmd_q <= uP_data;
              else if (cnt_q == CNT_W'(1)) addr_q <= uP_data;
              else wdata_q <= {uP_data, wdata_q[31:8]};
              hs2_q   <= 1'b1;
              state_q <= RX_WAIT_H1_LOW;
            end
          end
          RX_WAIT_H1_LOW: begin
            if (!h1_s) begin
              hs2_q <= 1'b0;
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_W'(RX_BYTES - 1)) begin
                req_q   <= 1'b1;
                state_q <= EXEC;
              end else begin
                state_q <= RX_WAIT_H1;
              end
            end
          end
          EXEC: begin
            if (bus_ack) begin
              req_q    <= 1'b0;
              tx_img_q <= {bus_status, bus_rdata};
              cnt_q    <= '0;
              state_q  <= TX_PRESENT;
            end
          end
          TX_PRESENT: begin
            hs2_q   <= 1'b1;
            state_q <= TX_WAIT_H1;
          end
          TX_WAIT_H1: begin
            if (h1_s) begin
              hs2_q   <= 1'b0;
              state_q <= TX_WAIT_H1_LOW;
            end
          end
          TX_WAIT_H1_LOW: begin
            if (!h1_s) begin
              cnt_q    <= cnt_q + CNT_W'(1);
              tx_img_q <= {8'h00, tx_img_q[63:8]};
              state_q  <= (cnt_q == CNT_W'(TX_BYTES - 1)) ? DONE : TX_PRESENT;
            end
          end
          DONE: begin
            ack_q   <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign uP_handshake_2 = hs2_q;
  assign uP_ack         = ack_q;
  assign bus_req        = req_q;
  assign bus_cmd        = cmd_q;
  assign bus_addr       = addr_q;
  assign bus_wdata      = wdata_q;

endmodule

// File: tb/tb_up_bus_responder.sv
// Directed bench for up_bus_responder: models the uP handshake master and the register bank.
module tb_up_bus_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, h1 = 1'b0, rw = 1'b1;
  logic        tb_drv = 1'b1;
  logic [7:0]  tb_byte = 8'hA5;
  wire  [7:0]  uP_data;
  logic        uP_handshake_2, uP_ack, bus_req, timeout_err;
  logic [7:0]  bus_cmd, bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0, bus_status = '0;

  int n_chk = 0, n_fail = 0;
  logic [63:0] rx_img;

  // Register-bank model state
  int          bank_delay = 4;
  logic [31:0] bank_rdata = '0, bank_status = '0;
  int          bank_cnt = 0, req_count = 0, last_req_cycles = 0, hs2_in_exec = 0;
  bit          ack_sent = 1'b0;
  logic [7:0]  cap_cmd = '0, cap_addr = '0;
  logic [31:0] cap_wdata = '0;

  always #10 clk = ~clk;

  assign uP_data = tb_drv ? tb_byte : 8'hzz;

`ifdef UP_BUS_TIMEOUT_EN
  up_bus_responder #(.TIMEOUT_CYCLES(50)) dut (
`else
  up_bus_responder dut (
`endif
    .clk(clk), .reset(reset),
    .async_uP_start(start), .async_uP_handshake_1(h1), .async_uP_RW(rw),
    .uP_handshake_2(uP_handshake_2), .uP_ack(uP_ack), .uP_data(uP_data),
    .bus_req(bus_req), .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_status(bus_status),
    .timeout_err(timeout_err)
  );

  // Register bank: acks bank_delay cycles after bus_req rises, one-cycle pulse
  always @(posedge clk) begin
    #1;
    bus_ack = 1'b0;
    if (bus_req && !ack_sent) begin
      if (bank_cnt == 0) begin
        req_count++;
        cap_cmd = bus_cmd; cap_addr = bus_addr; cap_wdata = bus_wdata;
      end
      if (uP_handshake_2) hs2_in_exec++;
      bank_cnt++;
      if (bank_cnt >= bank_delay) begin
        bus_ack = 1'b1; bus_rdata = bank_rdata; bus_status = bank_status;
        ack_sent = 1'b1; last_req_cycles = bank_cnt;
      end
    end else if (!bus_req) begin
      bank_cnt = 0; ack_sent = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_hs2(input logic val, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (uP_handshake_2 === val) begin ok = 1'b1; break; end
    end
  endtask

  task automatic up_start();
    @(posedge clk); #1; start = 1'b1;
    repeat (3) @(posedge clk);
    #1; start = 1'b0;
  endtask

  task automatic up_write_byte(input logic [7:0] b);
    bit ok;
    rw = 1'b1; tb_byte = b; tb_drv = 1'b1;
    @(posedge clk); #1; h1 = 1'b1;
    wait_hs2(1'b1, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL wr_hs2_rise: byte %h handshake_2=%b required 1", b, uP_handshake_2); end
    h1 = 1'b0;
    wait_hs2(1'b0, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL wr_hs2_fall: byte %h handshake_2=%b required 0", b, uP_handshake_2); end
  endtask

  task automatic up_send_cmd(input logic [7:0] cmd, input logic [7:0] addr, input logic [31:0] wd);
    up_write_byte(cmd);
    up_write_byte(addr);
    for (int i = 0; i < 4; i++) up_write_byte(wd[8*i +: 8]);
  endtask

  // Reads bytes first..7 into rx_img; holds h1 high for 'hold' checked cycles after handshake_2 drops
  task automatic up_read_bytes(input int first, input int hold);
    bit ok;
    rw = 1'b0; tb_drv = 1'b0;
    for (int i = first; i < 8; i++) begin
      wait_hs2(1'b1, ok);
      n_chk++;
      if (!ok) begin n_fail++; $display("FAIL rd_hs2_rise: byte %0d handshake_2=%b required 1", i, uP_handshake_2); end
      rx_img[8*i +: 8] = uP_data;
      h1 = 1'b1;
      wait_hs2(1'b0, ok);
      n_chk++;
      if (!ok) begin n_fail++; $display("FAIL rd_hs2_fall: byte %0d handshake_2=%b required 0", i, uP_handshake_2); end
      for (int c = 0; c < hold; c++) begin
        @(posedge clk); #1;
        n_chk++;
        if (uP_handshake_2 !== 1'b0) begin
          n_fail++; $display("FAIL hs2_early: byte %0d cycle %0d handshake_2=%b required 0", i, c, uP_handshake_2);
        end
      end
      h1 = 1'b0;
    end
  endtask

  task automatic up_wait_ack(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (uP_ack === 1'b1) begin ok = 1'b1; break; end
    end
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL %s: uP_ack=%b required 1", tag, uP_ack); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (uP_handshake_2 !== 1'b0) begin n_fail++; $display("FAIL rst_hs2: got %b required 0", uP_handshake_2); end
    n_chk++; if (uP_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b required 0", uP_ack); end
    n_chk++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b required 0", bus_req); end
    n_chk++; if (bus_cmd !== 8'h00) begin n_fail++; $display("FAIL rst_cmd: got %h required 00", bus_cmd); end
    n_chk++; if (bus_addr !== 8'h00) begin n_fail++; $display("FAIL rst_addr: got %h required 00", bus_addr); end
    n_chk++; if (bus_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h required 0", bus_wdata); end
    n_chk++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_tmo: got %b required 0", timeout_err); end
    n_chk++; if (uP_data !== 8'hA5) begin n_fail++; $display("FAIL rst_bus: got %h required A5", uP_data); end
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_chk++; if (uP_handshake_2 !== 1'b0) begin n_fail++; $display("FAIL idle_hs2: got %b required 0", uP_handshake_2); end
    n_chk++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b required 0", bus_req); end
  endtask

  task automatic test_write();
    int rq0 = req_count;
    bank_rdata = 32'h0000_0064; bank_status = 32'h0; bank_delay = 4;
    up_start();
    up_send_cmd(8'h01, 8'h05, 32'h0000_0064);
    rx_img = '0;
    up_read_bytes(0, 0);
    up_wait_ack("wr_ack");
    n_chk++; if (req_count - rq0 !== 1) begin n_fail++; $display("FAIL wr_reqs: got %0d required 1", req_count - rq0); end
    n_chk++; if (cap_cmd !== 8'h01) begin n_fail++; $display("FAIL wr_cmd: got %h required 01", cap_cmd); end
    n_chk++; if (cap_addr !== 8'h05) begin n_fail++; $display("FAIL wr_addr: got %h required 05", cap_addr); end
    n_chk++; if (cap_wdata !== 32'h0000_0064) begin n_fail++; $display("FAIL wr_wdata: got %h required 00000064", cap_wdata); end
    n_chk++; if (rx_img !== 64'h0000_0000_0000_0064) begin n_fail++; $display("FAIL wr_rx: got %h required 0000000000000064", rx_img); end
    n_chk++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL wr_req_drop: got %b required 0", bus_req); end
  endtask

  task automatic test_read();
    bit ok;
    bank_rdata = 32'hDEAD_BEEF; bank_status = 32'h0000_0001; bank_delay = 4;
    up_start();
    n_chk++; if (uP_ack !== 1'b0) begin n_fail++; $display("FAIL ack_clear: got %b required 0", uP_ack); end
    up_send_cmd(8'h00, 8'h05, 32'h0);
    // Keep RW high into the TX phase: the responder must stay off the bus
    rw = 1'b1; tb_drv = 1'b1; tb_byte = 8'h00;
    wait_hs2(1'b1, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rd_first_hs2: got %b required 1", uP_handshake_2); end
    @(posedge clk); #1;
    n_chk++; if (uP_data !== 8'h00) begin n_fail++; $display("FAIL rd_release_rw1: got %h required 00", uP_data); end
    rw = 1'b0; tb_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (uP_data !== 8'hEF) begin n_fail++; $display("FAIL rd_drive_rw0: got %h required EF", uP_data); end
    rx_img = '0;
    rx_img[7:0] = uP_data;
    h1 = 1'b1;
    wait_hs2(1'b0, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rd_first_fall: got %b required 0", uP_handshake_2); end
    h1 = 1'b0;
    up_read_bytes(1, 0);
    up_wait_ack("rd_ack");
    n_chk++; if (cap_cmd !== 8'h00) begin n_fail++; $display("FAIL rd_cmd: got %h required 00", cap_cmd); end
    n_chk++; if (rx_img !== 64'h0000_0001_DEAD_BEEF) begin n_fail++; $display("FAIL rd_rx: got %h required 00000001DEADBEEF", rx_img); end
  endtask

  task automatic test_handshake();
    bit ok;
    int lat = 0;
    bank_rdata = 32'h1122_3344; bank_status = 32'h5566_7788; bank_delay = 4;
    up_start();
    rw = 1'b1; tb_drv = 1'b1; tb_byte = 8'h01;
    @(posedge clk); #1; h1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (uP_handshake_2 === 1'b1) break;
    end
    n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL hs_latency: got %0d cycles required 3", lat); end
    h1 = 1'b0;
    wait_hs2(1'b0, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL hs_fall: got %b required 0", uP_handshake_2); end
    up_write_byte(8'h10);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] wd = 32'hA5A5_0F0F;
      up_write_byte(wd[8*i +: 8]);
    end
    rx_img = '0;
    up_read_bytes(0, 8);
    up_wait_ack("hs_ack");
    n_chk++; if (cap_addr !== 8'h10) begin n_fail++; $display("FAIL hs_addr: got %h required 10", cap_addr); end
    n_chk++; if (cap_wdata !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL hs_wdata: got %h required A5A50F0F", cap_wdata); end
    n_chk++; if (rx_img !== 64'h5566_7788_1122_3344) begin n_fail++; $display("FAIL hs_rx: got %h required 5566778811223344", rx_img); end
  endtask

  task automatic test_reset_mid();
    int rq0 = req_count;
    bank_rdata = 32'hCAFE_F00D; bank_status = 32'h0000_0002; bank_delay = 6;
    up_start();
    up_write_byte(8'h01);
    up_write_byte(8'h09);
    up_write_byte(8'hAA);
    @(posedge clk); #1; reset = 1'b1; tb_byte = 8'h3C;
    @(posedge clk); #1;
    n_chk++; if (uP_handshake_2 !== 1'b0) begin n_fail++; $display("FAIL mid_hs2: got %b required 0", uP_handshake_2); end
    n_chk++; if (bus_cmd !== 8'h00) begin n_fail++; $display("FAIL mid_cmd: got %h required 00", bus_cmd); end
    n_chk++; if (bus_addr !== 8'h00) begin n_fail++; $display("FAIL mid_addr: got %h required 00", bus_addr); end
    n_chk++; if (uP_data !== 8'h3C) begin n_fail++; $display("FAIL mid_bus: got %h required 3C", uP_data); end
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_chk++; if (req_count !== rq0) begin n_fail++; $display("FAIL mid_noreq: got %0d requests required %0d", req_count, rq0); end
    n_chk++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL mid_req: got %b required 0", bus_req); end
    n_chk++; if (uP_ack !== 1'b0) begin n_fail++; $display("FAIL mid_ack: got %b required 0", uP_ack); end
    up_start();
    up_send_cmd(8'h01, 8'h07, 32'hCAFE_F00D);
    rx_img = '0;
    up_read_bytes(0, 0);
    up_wait_ack("mid_next_ack");
    n_chk++; if (req_count - rq0 !== 1) begin n_fail++; $display("FAIL mid_next_reqs: got %0d required 1", req_count - rq0); end
    n_chk++; if (cap_addr !== 8'h07) begin n_fail++; $display("FAIL mid_next_addr: got %h required 07", cap_addr); end
    n_chk++; if (cap_wdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL mid_next_wdata: got %h required CAFEF00D", cap_wdata); end
    n_chk++; if (rx_img !== 64'h0000_0002_CAFE_F00D) begin n_fail++; $display("FAIL mid_next_rx: got %h required 00000002CAFEF00D", rx_img); end
  endtask

  task automatic test_slow_ack();
    int hx0 = hs2_in_exec;
    bank_rdata = 32'h0000_0100; bank_status = 32'h0; bank_delay = 100;
    up_start();
    up_send_cmd(8'h01, 8'h02, 32'h0000_0100);
    rx_img = '0;
    up_read_bytes(0, 0);
    up_wait_ack("slow_ack");
    n_chk++; if (last_req_cycles !== 100) begin n_fail++; $display("FAIL slow_req_len: got %0d cycles required 100", last_req_cycles); end
    n_chk++; if (hs2_in_exec !== hx0) begin n_fail++; $display("FAIL slow_hs2: handshake_2 high %0d cycles during request, required 0", hs2_in_exec - hx0); end
    n_chk++; if (rx_img !== 64'h0000_0000_0000_0100) begin n_fail++; $display("FAIL slow_rx: got %h required 0000000000000100", rx_img); end
  endtask

`ifdef UP_BUS_TIMEOUT_EN
  task automatic test_timeout();
    int t = 0;
    bank_rdata = 32'h0000_0077; bank_status = 32'h0; bank_delay = 4;
    up_start();
    up_write_byte(8'h01);
    up_write_byte(8'h03);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      t++;
      if (timeout_err === 1'b1) break;
    end
    n_chk++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b required 1", timeout_err); end
    n_chk++; if (t < 48 || t > 52) begin n_fail++; $display("FAIL to_time: got %0d cycles required 48..52", t); end
    @(posedge clk); #1;
    n_chk++; if (uP_ack !== 1'b0) begin n_fail++; $display("FAIL to_ack: got %b required 0", uP_ack); end
    n_chk++; if (uP_handshake_2 !== 1'b0) begin n_fail++; $display("FAIL to_hs2: got %b required 0", uP_handshake_2); end
    n_chk++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL to_req: got %b required 0", bus_req); end
    up_start();
    up_send_cmd(8'h00, 8'h04, 32'h0);
    rx_img = '0;
    up_read_bytes(0, 0);
    up_wait_ack("to_next_ack");
    n_chk++; if (rx_img !== 64'h0000_0000_0000_0077) begin n_fail++; $display("FAIL to_next_rx: got %h required 0000000000000077", rx_img); end
    n_chk++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b required 1", timeout_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_handshake();
    test_reset_mid();
    test_slow_ack();
`ifdef UP_BUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
